julia_pixel_sequencer: RTL and testbench

JULIA_PIXEL_SEQUENCER -- requirements
Module: julia_pixel_sequencer

---
 rtl/julia_pixel_sequencer.sv | 125 ++++++++++++
 tb/tb_julia_pixel_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_sequencer.sv
// Raster sequencer for a per-pixel Julia calculator: walks the frame, drives the
// calculator handshake and writes each returned colour to the frame buffer.
module julia_pixel_sequencer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [31:0]  x_start,
  input  logic signed [31:0]  y_start,
  input  logic signed [31:0]  x_step,
  input  logic signed [31:0]  y_step,
  output logic                calc_enable,
  output logic signed [31:0]  calc_x0,
  output logic signed [31:0]  calc_y0,
  input  logic                calc_end,
  input  logic [15:0]         calc_color,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [15:0]         fb_data,
  input  logic                fb_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, NEXT, DONE} state_t;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic signed [31:0]  x_start_l, x_step_l, y_step_l;
  logic [1:0]          rst_sync;
  logic                rst_int_n;

  // Assertion is asynchronous; release is delayed two edges so the FSM leaves reset cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      calc_enable <= 1'b0;
      fb_we       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      calc_x0     <= '0;
      calc_y0     <= '0;
      fb_addr     <= '0;
      fb_data     <= '0;
      col         <= '0;
      row         <= '0;
      x_start_l   <= '0;
      x_step_l    <= '0;
      y_step_l    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_start_l <= x_start;
            x_step_l  <= x_step;
            y_step_l  <= y_step;
            calc_x0   <= x_start;
            calc_y0   <= y_start;
            col       <= '0;
            row       <= '0;
            fb_addr   <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          calc_enable <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (calc_end) begin
            fb_data     <= calc_color;
            calc_enable <= 1'b0;
            fb_we       <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (fb_ready) begin
            fb_we <= 1'b0;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (col != COL_LAST) begin
            col     <= col + COL_W'(1);
            calc_x0 <= calc_x0 + x_step_l;
            fb_addr <= fb_addr + ADDR_W'(1);
            state   <= LOAD;
          end else if (row != ROW_LAST) begin
            col     <= '0;
            row     <= row + ROW_W'(1);
            calc_x0 <= x_start_l;
            calc_y0 <= calc_y0 + y_step_l;
            fb_addr <= fb_addr + ADDR_W'(1);
            state   <= LOAD;
          end else begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// Scoreboard bench for julia_pixel_sequencer on a 4x2 frame with a 3-cycle calculator
// model; coordinates are Q24.8 so colours (low 16 bits of x^y) are non-trivial.
module tb_julia_pixel_sequencer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;
  localparam logic [31:0] ONE = 32'h0000_0100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic signed [31:0] x_start = '0, y_start = '0, x_step = '0, y_step = '0;
  logic               calc_enable;
  logic signed [31:0] calc_x0, calc_y0;
  logic               calc_end = 1'b0;
  logic [15:0]        calc_color;
  logic               fb_we;
  logic [AW-1:0]      fb_addr;
  logic [15:0]        fb_data;
  logic               fb_ready = 1'b1;
  logic               busy, frame_done;

  julia_pixel_sequencer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_start(x_start), .y_start(y_start), .x_step(x_step), .y_step(y_step),
    .calc_enable(calc_enable), .calc_x0(calc_x0), .calc_y0(calc_y0),
    .calc_end(calc_end), .calc_color(calc_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [31:0] x; logic [31:0] y; } xy_t;
  wr_t exp_wr[$];
  xy_t exp_xy[$];

  int checks = 0, errors = 0;
  int wr_count = 0, done_count = 0, en_rises = 0, we_len2 = 0;
  bit bp_arm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Calculator model: calc_end rises 3 cycles after enable, held until enable falls.
  assign calc_color = calc_x0[15:0] ^ calc_y0[15:0];
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!calc_enable) begin cnt = 0; calc_end = 1'b0; end
      else if (cnt == 2) calc_end = 1'b1;
      else cnt++;
    end
  end

  // Frame-buffer model: one 5-cycle stall on address 2 when armed.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (bp_arm && fb_we && fb_addr == AW'(2)) begin
        fb_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 fb_ready = 1'b1;
        bp_arm = 1'b0;
      end
    end
  end

  // Monitor: pops expectations on calc_enable rise and on each accepted write.
  initial begin
    logic        prev_en = 1'b0, prev_we = 1'b0;
    logic [31:0] cap_x = '0, cap_y = '0, prev_addr = '0;
    logic [15:0] prev_data = '0;
    int          we_run = 0;
    xy_t e_xy;
    wr_t e_wr;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (calc_enable && !prev_en) begin
          en_rises++;
          cap_x = calc_x0; cap_y = calc_y0;
          checks++;
          if (exp_xy.size() == 0) begin
            errors++;
            $display("FAIL coord_unexpected: got x0=%h y0=%h, expected no pixel", calc_x0, calc_y0);
          end else begin
            e_xy = exp_xy.pop_front();
            chk("calc_x0", calc_x0, e_xy.x);
            chk("calc_y0", calc_y0, e_xy.y);
          end
        end else if (calc_enable) begin
          chk("x0_stable", calc_x0, cap_x);
          chk("y0_stable", calc_y0, cap_y);
        end
        if (fb_we) begin
          chk("en_during_we", {31'd0, calc_enable}, 32'd0);
          we_run = prev_we ? we_run + 1 : 1;
          if (prev_we) begin
            chk("addr_stable", {29'd0, fb_addr}, prev_addr);
            chk("data_stable", {16'd0, fb_data}, {16'd0, prev_data});
          end
          if (fb_ready) begin
            wr_count++;
            if (fb_addr == AW'(2)) we_len2 = we_run;
            checks++;
            if (exp_wr.size() == 0) begin
              errors++;
              $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", fb_addr, fb_data);
            end else begin
              e_wr = exp_wr.pop_front();
              chk("fb_addr", {29'd0, fb_addr}, e_wr.addr);
              chk("fb_data", {16'd0, fb_data}, {16'd0, e_wr.data});
            end
          end
        end
        if (frame_done) begin
          done_count++;
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      prev_en = calc_enable; prev_we = fb_we;
      prev_addr = {29'd0, fb_addr}; prev_data = fb_data;
    end
  end

  task automatic begin_frame(input logic [31:0] xs, input logic [31:0] ys,
                             input logic [31:0] dx, input logic [31:0] dy);
    x_start = xs; y_start = ys; x_step = dx; y_step = dy;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        logic [31:0] x, y;
        x = xs + dx * c;
        y = ys + dy * r;
        exp_xy.push_back('{x: x, y: y});
        exp_wr.push_back('{addr: r * H + c, data: x[15:0] ^ y[15:0]});
      end
    wr_count = 0; done_count = 0; en_rises = 0; we_len2 = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_pix(input int addr);
    int n = 0;
    while (!(calc_enable && fb_addr == AW'(addr)) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wait_pixel: got timeout, expected calc_enable at addr %0d", addr);
    end
  endtask

  // Waits for frame_done; a start pulse is issued in the DONE cycle, which must be ignored.
  task automatic end_frame(input string tag);
    int n = 0;
    while (!frame_done && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no frame_done, expected one", tag);
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_writes"}, wr_count, 8);
    chk({tag, "_done_pulses"}, done_count, 1);
    chk({tag, "_en_windows"}, en_rises, 8);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_last_addr"}, {29'd0, fb_addr}, 32'd7);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_calc_enable", {31'd0, calc_enable}, 32'd0);
    chk("rst_fb_we", {31'd0, fb_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_fb_addr", {29'd0, fb_addr}, 32'd0);
    chk("rst_fb_data", {16'd0, fb_data}, 32'd0);
    chk("rst_calc_x0", calc_x0, 32'd0);
    chk("rst_calc_y0", calc_y0, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full frame: x -2.0 step 1.0, y -1.0 step 2.0
    begin_frame(32'hFFFF_FE00, 32'hFFFF_FF00, ONE, 2 * ONE);
    end_frame("full");

    // Backpressure on pixel 2
    bp_arm = 1'b1;
    begin_frame(32'hFFFF_FE00, 32'hFFFF_FF00, ONE, 2 * ONE);
    end_frame("bp");
    chk("bp_we_cycles", we_len2, 6);

    // Start while busy with changed coordinates
    begin_frame(32'hFFFF_FE00, 32'hFFFF_FF00, ONE, 2 * ONE);
    wait_pix(3);
    y_start = 32'h0000_5500; x_start = 32'h0000_3300;
    x_step = 32'h0000_0011; y_step = 32'h0000_0022;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    end_frame("busy_start");

    // Reset during RUN of pixel 5, then a fresh frame
    begin_frame(32'hFFFF_FE00, 32'hFFFF_FF00, ONE, 2 * ONE);
    wait_pix(5);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_calc_enable", {31'd0, calc_enable}, 32'd0);
    chk("midrst_fb_we", {31'd0, fb_we}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_wr.delete(); exp_xy.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_writes", wr_count, 5);
    chk("midrst_no_done", done_count, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    begin_frame(32'hFFFF_FE00, 32'hFFFF_FF00, ONE, 2 * ONE);
    end_frame("after_rst");

    // Two's-complement wrap on x
    begin_frame(32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0001, ONE);
    end_frame("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
